// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay/sound timer sequencer: divides clk_in down to the 60 Hz tick and
// decrements DT/ST in the register region through single-byte read-modify-write requests.
module chip8_timer_ctrl #(
  parameter int unsigned TICK_CYCLES = 1666667,
  parameter logic [11:0] DT_ADDR     = 12'd21,
  parameter logic [11:0] ST_ADDR     = 12'd22,
  parameter logic [1:0]  REG_TYPE    = 2'd1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        mem_ready_in,
  output logic        mem_valid_out,
  output logic [11:0] mem_addr_out,
  output logic [1:0]  mem_type_out,
  output logic        mem_we_out,
  output logic        mem_size_out,
  output logic [15:0] mem_data_out,
  input  logic        mem_valid_in,
  input  logic [15:0] mem_data_in,
  output logic        sound_out,
  output logic        busy_out,
  output logic        missed_tick_out
);

  localparam int unsigned      DIV_W    = $clog2(TICK_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_DT, WAIT_DT, WR_DT, RD_ST, WAIT_ST, WR_ST
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
  } mem_req_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             pending_q;
  logic             missed_q;
  logic             sound_q;
  logic [7:0]       wr_byte_q;
  logic             tick;
  logic             start;
  logic             rd_cap;
  logic [7:0]       rd_byte;
  mem_req_t         req;

  assign rd_byte = mem_data_in[7:0];
  assign tick    = enable_in && (div_q == DIV_LAST);
  // A tick seen in IDLE starts at once so the first request lands the cycle after it.
  assign start   = (state_q == IDLE) && enable_in && (pending_q || tick);
  assign rd_cap  = mem_valid_in && ((state_q == WAIT_DT) || (state_q == WAIT_ST));

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q     <= '0;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
      sound_q   <= 1'b0;
      wr_byte_q <= 8'h00;
    end else begin
      if (enable_in) div_q <= tick ? '0 : div_q + DIV_W'(1);
      // Pending saturates at one; a tick that finds it already set is reported as missed.
      pending_q <= start ? (pending_q & tick) : (pending_q | tick);
      missed_q  <= tick & pending_q & ~start;
      if (rd_cap) wr_byte_q <= rd_byte - 8'd1;
      if (mem_valid_in && (state_q == WAIT_ST)) sound_q <= (rd_byte > 8'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    req     = '0;
    unique case (state_q)
      IDLE: if (start) state_d = RD_DT;
      RD_DT: begin
        req.valid = 1'b1;
        req.addr  = DT_ADDR;
        if (mem_ready_in) state_d = WAIT_DT;
      end
      WAIT_DT: if (mem_valid_in) state_d = (rd_byte != 8'h00) ? WR_DT : RD_ST;
      WR_DT: begin
        req.valid = 1'b1;
        req.we    = 1'b1;
        req.addr  = DT_ADDR;
        req.data  = wr_byte_q;
        if (mem_ready_in) state_d = RD_ST;
      end
      RD_ST: begin
        req.valid = 1'b1;
        req.addr  = ST_ADDR;
        if (mem_ready_in) state_d = WAIT_ST;
      end
      WAIT_ST: if (mem_valid_in) state_d = (rd_byte != 8'h00) ? WR_ST : IDLE;
      WR_ST: begin
        req.valid = 1'b1;
        req.we    = 1'b1;
        req.addr  = ST_ADDR;
        req.data  = wr_byte_q;
        if (mem_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_valid_out   = req.valid;
  assign mem_we_out      = req.we;
  assign mem_addr_out    = req.addr;
  assign mem_data_out    = {8'h00, req.data};
  assign mem_type_out    = req.valid ? REG_TYPE : 2'b00;
  assign mem_size_out    = 1'b0;
  assign busy_out        = (state_q != IDLE);
  assign sound_out       = sound_q;
  assign missed_tick_out = missed_q;

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Bench for chip8_timer_ctrl: register-byte memory model with fixed read latency and
// a scoreboard of expected requests popped as the DUT's requests are accepted.
module tb_chip8_timer_ctrl;
  localparam int TC = 16;
  localparam int L  = 3;

  typedef struct packed {
    logic [1:0]  typ;
    logic        we;
    logic        sz;
    logic [11:0] addr;
    logic [15:0] data;
  } req_t;

  logic        clk_in = 1'b0;
  logic        rst_in, enable_in, mem_ready_in, mem_valid_in;
  logic [15:0] mem_data_in;
  logic        mem_valid_out, mem_we_out, mem_size_out;
  logic [11:0] mem_addr_out;
  logic [1:0]  mem_type_out;
  logic [15:0] mem_data_out;
  logic        sound_out, busy_out, missed_tick_out;

  always #5 clk_in = ~clk_in;

  chip8_timer_ctrl #(.TICK_CYCLES(TC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .mem_ready_in(mem_ready_in),
    .mem_valid_out(mem_valid_out), .mem_addr_out(mem_addr_out), .mem_type_out(mem_type_out),
    .mem_we_out(mem_we_out), .mem_size_out(mem_size_out), .mem_data_out(mem_data_out),
    .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in), .sound_out(sound_out),
    .busy_out(busy_out), .missed_tick_out(missed_tick_out)
  );

  int         n_chk = 0, n_pass = 0;
  int         n_rd = 0, n_wr = 0, n_missed = 0;
  int         resp_cnt = 0;
  logic [4:0] resp_addr = '0;
  logic       hold_resp = 1'b0;
  logic [7:0] mem [0:31];
  logic [7:0] mdt, mst;
  req_t       sb [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic req_t mk(input logic we, input logic [11:0] a, input logic [7:0] d);
    mk = '{typ: 2'd1, we: we, sz: 1'b0, addr: a, data: {8'h00, d}};
  endfunction

  // Expected requests for one tick, from the bench's own DT/ST model.
  task automatic push_seq();
    sb.push_back(mk(1'b0, 12'd21, 8'h00));
    if (mdt != 8'h00) begin mdt = mdt - 8'd1; sb.push_back(mk(1'b1, 12'd21, mdt)); end
    sb.push_back(mk(1'b0, 12'd22, 8'h00));
    if (mst != 8'h00) begin mst = mst - 8'd1; sb.push_back(mk(1'b1, 12'd22, mst)); end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_busy(input string tag, input int lim, input logic lvl);
    int n = 0;
    while (busy_out !== lvl && n < lim) begin cyc(); n++; end
    chk(tag, busy_out, lvl);
  endtask

  task automatic set_regs(input logic [7:0] dt, input logic [7:0] st);
    mem[21] = dt; mem[22] = st; mdt = dt; mst = st;
  endtask

  // Memory responder and request monitor, evaluated away from the active edge.
  initial begin
    req_t act, e;
    forever begin
      @(negedge clk_in);
      mem_valid_in = 1'b0;
      mem_data_in  = 16'h0000;
      if (rst_in) resp_cnt = 0;
      else if (resp_cnt > 0 && !(resp_cnt == 1 && hold_resp)) begin
        resp_cnt--;
        if (resp_cnt == 0) begin mem_valid_in = 1'b1; mem_data_in = {8'hA5, mem[resp_addr]}; end
      end
      if (missed_tick_out) n_missed++;
      if (mem_valid_out) chk("valid_only_when_busy", busy_out, 1'b1);
      if (mem_valid_out && mem_ready_in && !rst_in) begin
        act = '{typ: mem_type_out, we: mem_we_out, sz: mem_size_out, addr: mem_addr_out,
                data: mem_we_out ? mem_data_out : 16'h0000};
        if (mem_we_out) n_wr++; else n_rd++;
        chk("req_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin e = sb.pop_front(); chk("req", act, e); end
        if (mem_we_out) mem[mem_addr_out[4:0]] = mem_data_out[7:0];
        else begin resp_cnt = L; resp_addr = mem_addr_out[4:0]; end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int n, len, stable, rd0, wr0, ms0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rst_in = 1'b1; enable_in = 1'b0; mem_ready_in = 1'b1;
    mem_valid_in = 1'b0; mem_data_in = 16'h0000;
    repeat (3) cyc();
    chk("rst_valid", mem_valid_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_misc", {sound_out, missed_tick_out, mem_we_out, mem_size_out, mem_type_out}, 0);
    chk("rst_addr_data", {mem_addr_out, mem_data_out}, 0);

    // Divider holds while disabled: 7 counts, 100 idle, then 9 more to the tick.
    set_regs(8'd5, 8'd2);
    push_seq();
    rst_in = 1'b0; enable_in = 1'b1;
    repeat (7) cyc();
    enable_in = 1'b0;
    repeat (100) cyc();
    chk("no_req_while_disabled", n_rd + n_wr, 0);
    enable_in = 1'b1;
    n = 0;
    while (!mem_valid_out && n < 40) begin cyc(); n++; end
    chk("reenable_tick_latency", n, 9);
    len = 0;
    while (busy_out === 1'b1 && len < 40) begin len++; cyc(); end
    chk("seq_len_two_writes", len, 2 + 2 * L + 2);
    chk("dt_after_tick1", mem[21], mdt);
    chk("st_after_tick1", mem[22], mst);
    chk("sound_st2", sound_out, 1'b1);

    push_seq();
    wait_busy("tick2_start", 40, 1'b1);
    wait_busy("tick2_done", 40, 1'b0);
    enable_in = 1'b0;
    chk("dt_after_tick2", mem[21], mdt);
    chk("st_after_tick2", mem[22], mst);
    chk("sound_st1", sound_out, 1'b0);

    // Zero registers: two reads, no writes, no wrap to 255.
    set_regs(8'd0, 8'd0);
    push_seq();
    rd0 = n_rd; wr0 = n_wr;
    enable_in = 1'b1;
    wait_busy("zero_start", 40, 1'b1);
    len = 0;
    while (busy_out === 1'b1 && len < 40) begin len++; cyc(); end
    enable_in = 1'b0;
    chk("zero_seq_len", len, 2 + 2 * L);
    chk("zero_reads", n_rd - rd0, 2);
    chk("zero_writes", n_wr - wr0, 0);
    chk("zero_regs", {mem[21], mem[22]}, 16'h0000);

    // Back-pressure on the first read, with enable dropped mid-sequence.
    set_regs(8'd3, 8'd0);
    push_seq();
    mem_ready_in = 1'b0;
    enable_in = 1'b1;
    n = 0;
    while (!mem_valid_out && n < 40) begin cyc(); n++; end
    chk("stall_req_seen", mem_valid_out, 1'b1);
    enable_in = 1'b0;
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_valid_out && !mem_we_out && mem_addr_out == 12'd21 && mem_type_out == 2'd1) stable++;
      cyc();
    end
    chk("stall_req_held_20", stable, 20);
    mem_ready_in = 1'b1;
    cyc();
    chk("valid_drop_after_accept", mem_valid_out, 1'b0);
    wait_busy("stall_done", 40, 1'b0);
    chk("dt_after_stall", mem[21], mdt);
    chk("sound_after_stall", sound_out, 1'b0);

    // Withheld read response across two ticks: one pending, one missed.
    set_regs(8'd9, 8'd1);
    push_seq();
    push_seq();
    ms0 = n_missed;
    hold_resp = 1'b1;
    enable_in = 1'b1;
    wait_busy("hold_start", 40, 1'b1);
    repeat (2 * TC + 2) cyc();
    chk("hold_still_busy", busy_out, 1'b1);
    hold_resp = 1'b0;
    n = 0;
    while (sb.size() != 2 && n < 60) begin cyc(); n++; end
    chk("backtoback_started", sb.size(), 2);
    enable_in = 1'b0;
    wait_busy("backtoback_done", 60, 1'b0);
    chk("missed_pulses", n_missed - ms0, 1);
    chk("dt_after_backtoback", mem[21], 8'd7);
    chk("sb_drained", sb.size(), 0);

    // Reset during WR_ST (stalled by ready=0): no write, clean restart.
    set_regs(8'd0, 8'd3);
    sb.push_back(mk(1'b0, 12'd21, 8'h00));
    sb.push_back(mk(1'b0, 12'd22, 8'h00));
    enable_in = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin cyc(); n++; end
    mem_ready_in = 1'b0;
    n = 0;
    while (!(mem_valid_out && mem_we_out) && n < 20) begin cyc(); n++; end
    chk("wr_st_reached", {mem_valid_out, mem_we_out, mem_addr_out}, {2'b11, 12'd22});
    chk("sound_before_rst", sound_out, 1'b1);
    rst_in = 1'b1;
    cyc();
    chk("rst_mid_valid", mem_valid_out, 1'b0);
    chk("rst_mid_sound", sound_out, 1'b0);
    chk("rst_mid_busy", busy_out, 1'b0);
    rst_in = 1'b0;
    mem_ready_in = 1'b1;
    push_seq();
    n = 0;
    while (!mem_valid_out && n < 40) begin cyc(); n++; end
    chk("post_rst_tick_latency", n, 16);
    wait_busy("post_rst_done", 40, 1'b0);
    chk("st_after_rst_seq", mem[22], 8'd2);
    chk("dt_after_rst_seq", mem[21], 8'd0);
    chk("sound_after_rst_seq", sound_out, 1'b1);
    chk("sb_final", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chip8_timer_ctrl.md
Name: chip8_timer_ctrl

Overview:
- Sequences the CHIP-8 60 Hz delay/sound timers stored in the register region of the per-chip memory block.
- Once per tick it issues single-byte read-modify-write requests on one requester port of the memory block, decrementing DT (reg 21) and ST (reg 22) when they are nonzero.
- Drives the buzzer enable from the updated ST value.
- Sits between the tick divider and the memory arbiter, and competes with the processor and debug requesters.

Parameters:
TICK_CYCLES, 1666667, clk_in cycles per timer tick (100 MHz / 60); minimum legal value 16
DT_ADDR, 21, register-region byte offset of DT
ST_ADDR, 22, register-region byte offset of ST
REG_TYPE, 1, value driven on mem_type_out to select the register region

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
enable_in  input  1  1 = timers run; 0 = divider holds and no new sequence starts
mem_ready_in  input  1  memory requester port can accept a request
mem_valid_out  output  1  request valid
mem_addr_out  output  12  register offset (DT_ADDR or ST_ADDR)
mem_type_out  output  2  always REG_TYPE
mem_we_out  output  1  1 = write, 0 = read
mem_size_out  output  1  always 0 (single byte)
mem_data_out  output  16  write data; byte in [7:0], [15:8] = 0
mem_valid_in  input  1  read data valid pulse
mem_data_in  input  16  read data; byte in [7:0]
sound_out  output  1  ST nonzero after the last update
busy_out  output  1  sequence in progress (state != IDLE)
missed_tick_out  output  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset values: every output is 0; state = IDLE; divider = 0; pending = 0. Reset mid-sequence abandons the sequence immediately, drops mem_valid_out the next cycle, and writes nothing further.
- Divider:
  - Counts 0..TICK_CYCLES-1 while enable_in = 1 and holds its value while enable_in = 0.
  - A tick fires on the cycle the count wraps from TICK_CYCLES-1 to 0.
- Pending flag:
  - A tick sets pending.
  - IDLE with pending set and enable_in = 1 starts a sequence and clears pending.
  - A tick arriving while pending is already set pulses missed_tick_out for one cycle; pending stays 1 (saturating).
  - A tick arriving while busy, with pending clear, only sets pending.
- States: IDLE -> RD_DT -> WAIT_DT -> [WR_DT] -> RD_ST -> WAIT_ST -> [WR_ST] -> IDLE.
- RD_x:
  - Drive valid = 1, we = 0, addr = x_ADDR.
  - Hold all request fields stable until the cycle mem_ready_in = 1 (acceptance), then move to WAIT_x.
  - mem_valid_out is 0 the cycle after acceptance.
- WAIT_x:
  - Ignore all inputs except mem_valid_in. No timeout.
  - On mem_valid_in, capture byte v = mem_data_in[7:0].
  - If v != 0, go to WR_x with data = v - 1 (8-bit).
  - If v == 0, skip the write: go to RD_ST after DT, or to IDLE after ST. 0 never wraps to 255.
- WR_x:
  - Drive valid = 1, we = 1, data = {8'h00, v-1}, held until acceptance.
  - No response is awaited; go to the next state after acceptance.
- sound_out:
  - On the WAIT_ST capture cycle: sound_out <= (v > 1).
  - Holds between updates; unaffected by enable_in.
- enable_in falling mid-sequence: the sequence completes, and pending is retained.
- Requests are issued only from RD/WR states; mem_valid_out is never high in WAIT or IDLE.
- Latency with mem_ready_in tied to 1 and read response L cycles after acceptance:
  - Sequence is 2 + 2L + (number of writes) cycles from leaving IDLE.
  - The first request is asserted the cycle after the tick.

Test Plan:
- TICK_CYCLES=16, ready tied 1, response L=3, memory DT=5, ST=2: after the first tick → reads at 21 and 22, writes 21←4 and 22←1, sound_out=1; after the second tick ST=0 and sound_out=0.
- DT=0, ST=0: tick → exactly two reads, zero writes (mem_we_out never 1), DT/ST remain 0, busy_out back to 0 within 10 cycles.
- mem_ready_in held 0 for 20 cycles during RD_DT → addr=21, we=0, valid=1 held constant all 20 cycles; acceptance on cycle 21; sequence then completes normally.
- Withhold mem_valid_in for more than 2×TICK_CYCLES (DT=9) → first extra tick sets pending, second pulses missed_tick_out once; on release DT→8, then a second sequence runs back-to-back giving DT→7.
- enable_in=0 at divider count 7 for 100 cycles → no ticks; after re-enable the next tick arrives 9 cycles later.
- Assert rst_in for one cycle during WR_ST → next cycle mem_valid_out=0, sound_out=0, busy_out=0; no write issued after reset; first post-reset tick after 16 cycles.
